// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store sequencer: serialises a scalar or R-lane vector access into element transfers.
// Latency: R+2 cycles vector / 3 cycles scalar to DoneM with ready high; each mem_ready=0 cycle adds one.
module mem_stage_lsu #(
  parameter int N = 8,
  parameter int R = 6,
  parameter int A = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemReadM,
  input  logic                MemWriteM,
  input  logic                ScalarM,
  input  logic [A-1:0]        AddrM,
  input  logic [R-1:0][N-1:0] WriteDataM,
  output logic [A-1:0]        mem_addr,
  output logic [N-1:0]        mem_wdata,
  output logic                mem_re,
  output logic                mem_we,
  input  logic [N-1:0]        mem_rdata,
  input  logic                mem_ready,
  output logic [R-1:0][N-1:0] ReadDataM,
  output logic                StallM,
  output logic                DoneM
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [A-1:0]        base_q;
  logic [R-1:0][N-1:0] wdata_q;
  logic                scalar_q;

  logic                last;
  logic [IW-1:0]       idx_nxt;
  logic [A-1:0]        addr_nxt;

  // A scalar access has length one, so its only element is always the last.
  assign last     = scalar_q ? 1'b1 : (idx == IW'(R - 1));
  assign idx_nxt  = idx + IW'(1);
  assign addr_nxt = base_q + A'(idx_nxt);

  always_comb begin
    StallM = 1'b0;
    case (state)
      IDLE:        StallM = MemReadM | MemWriteM;
      READ, WRITE: StallM = 1'b1;
      default:     StallM = 1'b0;
    endcase
    if (!reset) StallM = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      base_q    <= '0;
      wdata_q   <= '0;
      scalar_q  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      ReadDataM <= '0;
      DoneM     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MemWriteM || MemReadM) begin
            base_q   <= AddrM;
            wdata_q  <= WriteDataM;
            scalar_q <= ScalarM;
            idx      <= '0;
            mem_addr <= AddrM;
            // Store takes priority when both requests are raised together.
            if (MemWriteM) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= WriteDataM[0];
            end else begin
              state  <= READ;
              mem_re <= 1'b1;
              if (ScalarM) begin
                for (int i = 1; i < R; i++) ReadDataM[i] <= '0;
              end
            end
          end
        end
        READ: begin
          if (mem_ready) begin
            ReadDataM[idx] <= mem_rdata;
            if (last) begin
              mem_re <= 1'b0;
              DoneM  <= 1'b1;
              state  <= DONE;
            end else begin
              idx      <= idx_nxt;
              mem_addr <= addr_nxt;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            if (last) begin
              mem_we <= 1'b0;
              DoneM  <= 1'b1;
              state  <= DONE;
            end else begin
              idx       <= idx_nxt;
              mem_addr  <= addr_nxt;
              mem_wdata <= wdata_q[idx_nxt];
            end
          end
        end
        DONE: begin
          DoneM <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a behavioural element-wide data memory.
module tb_mem_stage_lsu;

  logic            clk;
  logic            reset;
  logic            MemReadM, MemWriteM, ScalarM;
  logic [9:0]      AddrM;
  logic [5:0][7:0] WriteDataM;
  logic [9:0]      mem_addr;
  logic [7:0]      mem_wdata;
  logic            mem_re, mem_we;
  logic [7:0]      mem_rdata;
  logic            mem_ready;
  logic [5:0][7:0] ReadDataM;
  logic            StallM, DoneM;

  logic [7:0] tbmem [0:1023];
  logic [9:0] re_log [0:7];
  int         n_re;
  int         hold_left;
  logic [9:0] hold_addr;
  int         held;

  int checks = 0;
  int errors = 0;

  int   dc, sc;
  logic sre, swe;

  mem_stage_lsu #(.N(8), .R(6), .A(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ScalarM    (ScalarM),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .DoneM      (DoneM)
  );

  assign mem_rdata = tbmem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request and follows it to DoneM; cycle 1 is the cycle the request is presented.
  task automatic run_access(input logic rd, input logic wr, input logic scl,
                            input logic [9:0] addr, input logic [47:0] wd,
                            output int done_cyc, output int stall_cyc,
                            output logic saw_re, output logic saw_we);
    int c;
    MemReadM = rd; MemWriteM = wr; ScalarM = scl; AddrM = addr; WriteDataM = wd;
    done_cyc = 0; stall_cyc = 0; saw_re = 1'b0; saw_we = 1'b0; n_re = 0; held = 0;
    c = 0;
    #1;
    while (done_cyc == 0 && c < 40) begin
      c++;
      if (StallM) stall_cyc++;
      if (mem_re) saw_re = 1'b1;
      if (mem_we) saw_we = 1'b1;
      if (hold_left > 0 && mem_re && mem_addr == hold_addr) begin
        mem_ready = 1'b0;
        hold_left--;
        held++;
      end else begin
        mem_ready = 1'b1;
      end
      if (mem_re && mem_ready && n_re < 8) begin
        re_log[n_re] = mem_addr;
        n_re++;
      end
      if (mem_we && mem_ready) tbmem[mem_addr] = mem_wdata;
      if (DoneM) begin
        done_cyc = c;
        MemReadM = 1'b0;
        MemWriteM = 1'b0;
      end
      @(posedge clk);
      #2;
    end
    mem_ready = 1'b1;
    if (done_cyc == 0) check("access_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int found;
    int late_we;
    for (int i = 0; i < 1024; i++) tbmem[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tbmem[10'h010 + i] = 8'hA0 + 8'(i);
      tbmem[10'h030 + i] = 8'hFF;
      tbmem[10'h040 + i] = 8'hC0 + 8'(i);
    end
    tbmem[10'h020] = 8'h7F;
    hold_left = 0; hold_addr = '0; n_re = 0; held = 0;
    mem_ready = 1'b1;
    MemReadM = 1'b1; MemWriteM = 1'b0; ScalarM = 1'b0; AddrM = 10'h123; WriteDataM = '0;
    reset = 1'b0;

    #3;
    check("reset_ctrl", {60'd0, StallM, DoneM, mem_re, mem_we}, 64'd0);
    check("reset_addr", {54'd0, mem_addr}, 64'd0);
    check("reset_wdata", {56'd0, mem_wdata}, 64'd0);
    check("reset_rdata", ReadDataM, 64'd0);
    MemReadM = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;

    // 1: vector load
    run_access(1'b1, 1'b0, 1'b0, 10'h010, 48'd0, dc, sc, sre, swe);
    check("t1_done_cycle", dc, 8);
    check("t1_stall_cycles", sc, 7);
    check("t1_rdata", ReadDataM, 48'hA5A4A3A2A1A0);
    check("t1_num_reads", n_re, 6);
    for (int i = 0; i < 6; i++) check("t1_read_addr", {54'd0, re_log[i]}, 64'h010 + 64'(i));

    // 2: vector store wrapping past the top of memory
    run_access(1'b0, 1'b1, 1'b0, 10'h3FE, 48'h060504030201, dc, sc, sre, swe);
    check("t2_done_cycle", dc, 8);
    check("t2_no_read", {63'd0, sre}, 64'd0);
    check("t2_m3fe", tbmem[10'h3FE], 8'h01);
    check("t2_m3ff", tbmem[10'h3FF], 8'h02);
    check("t2_m000", tbmem[10'h000], 8'h03);
    check("t2_m001", tbmem[10'h001], 8'h04);
    check("t2_m002", tbmem[10'h002], 8'h05);
    check("t2_m003", tbmem[10'h003], 8'h06);
    check("t2_rdata_kept", ReadDataM, 48'hA5A4A3A2A1A0);

    // 3: scalar load clears the upper lanes
    run_access(1'b1, 1'b0, 1'b0, 10'h030, 48'd0, dc, sc, sre, swe);
    check("t3_prefill", ReadDataM, 48'hFFFFFFFFFFFF);
    run_access(1'b1, 1'b0, 1'b1, 10'h020, 48'd0, dc, sc, sre, swe);
    check("t3_done_cycle", dc, 3);
    check("t3_stall_cycles", sc, 2);
    check("t3_rdata", ReadDataM, 48'h00000000007F);

    // 4: vector load with two wait cycles on lane 3
    hold_left = 2; hold_addr = 10'h043;
    run_access(1'b1, 1'b0, 1'b0, 10'h040, 48'd0, dc, sc, sre, swe);
    check("t4_held_cycles", held, 2);
    check("t4_done_cycle", dc, 10);
    check("t4_stall_cycles", sc, 9);
    check("t4_rdata", ReadDataM, 48'hC5C4C3C2C1C0);
    check("t4_num_reads", n_re, 6);

    // 5: load and store together -> scalar store only
    run_access(1'b1, 1'b1, 1'b1, 10'h080, 48'h262524232221, dc, sc, sre, swe);
    check("t5_no_read", {63'd0, sre}, 64'd0);
    check("t5_wrote", {63'd0, swe}, 64'd1);
    check("t5_done_cycle", dc, 3);
    check("t5_m080", tbmem[10'h080], 8'h21);
    check("t5_m081", tbmem[10'h081], 8'h00);
    check("t5_rdata_kept", ReadDataM, 48'hC5C4C3C2C1C0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t5_idle_quiet", {60'd0, StallM, DoneM, mem_re, mem_we}, 64'd0);
      @(posedge clk); #2;
    end

    // 6: reset while lane 2 of a vector store is outstanding
    MemWriteM = 1'b1; MemReadM = 1'b0; ScalarM = 1'b0; AddrM = 10'h100;
    WriteDataM = 48'h161514131211;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      #1;
      if (mem_we && mem_addr == 10'h102) begin
        reset = 1'b0;
        found = 1;
      end else begin
        if (mem_we && mem_ready) tbmem[mem_addr] = mem_wdata;
        @(posedge clk); #2;
      end
    end
    check("t6_reached_lane2", found, 1);
    #1;
    check("t6_we_dropped", {63'd0, mem_we}, 64'd0);
    check("t6_stall_low", {63'd0, StallM}, 64'd0);
    check("t6_rdata_cleared", ReadDataM, 64'd0);
    MemWriteM = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    late_we = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (mem_we || mem_re) late_we++;
      if (mem_we && mem_ready) tbmem[mem_addr] = mem_wdata;
      @(posedge clk); #2;
    end
    check("t6_no_req_after", late_we, 0);
    check("t6_m100", tbmem[10'h100], 8'h11);
    check("t6_m101", tbmem[10'h101], 8'h12);
    for (int i = 2; i < 6; i++) check("t6_unwritten", tbmem[10'h100 + 10'(i)], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
